snake_head_stepper: RTL
=======================

Name: snake_head_stepper

Overview:
- Downstream consumer of the pacemaker tick (`out` of pacemaker, wired here to `pace`).
- On each accepted tick it advances the snake head one cell in the latched direction and reports wall collisions.
- It hands each new head coordinate to the snake body/FIFO stage over a valid/ready handshake.
- It also filters direction-button pulses so a direction reversal is never committed.

Parameters:
- GRID_W, 32, grid width in cells.
- GRID_H, 24, grid height in cells.
- XW, 5, head_x width; must satisfy 2**XW >= GRID_W.
- YW, 5, head_y width; must satisfy 2**YW >= GRID_H.
- START_X, 16, head x after reset.
- START_Y, 12, head y after reset.
- WRAP, 0, selects edge behaviour. 1 = edges wrap around. 0 = an edge step is a crash.

Ports:
- clk  in  1  system clock, same clock as the pacemaker.
- rst_n  in  1  asynchronous, active-low reset.
- pace  in  1  single-cycle tick from the pacemaker.
- run  in  1  game enable, level signal.
- btn_up  in  1  single-cycle, synchronous, debounced pulse.
- btn_right  in  1  single-cycle, synchronous, debounced pulse.
- btn_down  in  1  single-cycle, synchronous, debounced pulse.
- btn_left  in  1  single-cycle, synchronous, debounced pulse.
- step_ready  in  1  body stage can accept a step.
- step_valid  out  1  new head coordinate available.
- head_x  out  XW  current head column.
- head_y  out  YW  current head row.
- dir  out  2  committed direction: 0 up, 1 right, 2 down, 3 left.
- crash  out  1  sticky wall-collision flag.
- overrun  out  1  sticky flag: a pace tick arrived while a step was still unacknowledged.

Behaviour:
- Reset (async on rst_n low, released synchronously into IDLE): head_x=START_X, head_y=START_Y, dir=1, pend_dir=1, step_valid=0, crash=0, overrun=0.
- Direction latch:
  - A button pulse loads pend_dir unless the requested direction equals (dir+2) mod 4; reversals are dropped silently.
  - If several buttons pulse in the same cycle, priority is up > right > down > left. The priority pick is made first, then the reversal filter is applied.
  - Buttons are accepted in every state except CRASH.
  - Only the last legal press before a tick counts.
- States:
  - IDLE: ignore pace. Go to RUN when run=1.
  - RUN: on pace, dir<=pend_dir and the next coordinate is computed from pend_dir.
    - Wall hit with WRAP=0 (x=0 going left, x=GRID_W-1 going right, y=0 going up, y=GRID_H-1 going down): crash<=1, head unchanged, go to CRASH.
    - Wall hit with WRAP=1: the coordinate wraps to the opposite edge (0 <-> GRID_W-1 or 0 <-> GRID_H-1).
    - Otherwise: head updated on the same edge, step_valid<=1, go to WAIT.
    - Up decrements y; down increments y.
  - WAIT: hold step_valid, head_x and head_y stable.
    - When step_valid && step_ready: step_valid<=0 next edge, return to RUN (or IDLE if run=0).
    - A pace in WAIT is dropped and sets overrun<=1.
  - CRASH: terminal. Outputs frozen, pace and buttons ignored. Only rst_n exits.
- run deasserting in RUN returns to IDLE on the next edge. In WAIT the handshake completes first. Head position is retained.
- pace and step_ready asserted together in WAIT: the handshake completes, the tick is counted as overrun, and no new step is taken.
- Latency: one cycle from the pace edge to the registered head and step_valid.
- All outputs are registered.
- Coordinate arithmetic is unsigned modulo the grid size, never modulo 2**XW.

Decomposition:
- snake_pkg holds:
  - direction encodings DIR_UP/DIR_RIGHT/DIR_DOWN/DIR_LEFT;
  - a 2-bit direction typedef;
  - the state enum IDLE/RUN/WAIT/CRASH;
  - grid default constants shared with the body and render stages.
- One sub-module, snake_dir_filter, is natural: button priority, reversal rejection and the pend_dir register.

Test Plan:
- Reset, run=1, four pace ticks with step_ready=1 -> head (17,12), (18,12), (19,12), (20,12), with one step_valid pulse per tick.
- dir=right, btn_left pulse, then pace -> reversal rejected, head x+1. Then btn_up, pace -> dir=0, head y decrements by 1.
- btn_up and btn_left in the same cycle, then pace -> up is taken.
- WRAP=0: start x=31 moving right, pace -> crash=1, head stays (31,y). Later pace and button pulses -> no change until rst_n.
- WRAP=1: same stimulus -> head x=0, crash=0.
- step_ready held 0 across two pace ticks -> step_valid held, head stable, overrun=1. Raise step_ready -> step_valid drops next cycle.
- Assert rst_n low mid-WAIT -> all outputs immediately return to reset values.

Source files
------------

// File: rtl/snake_pkg.sv
// snake_pkg: definitions shared by the snake game stages.
//   dir_t   : 2-bit direction code (0 up, 1 right, 2 down, 3 left)
//   state_t : head stepper control states
//   grid defaults shared with the body and render stages
package snake_pkg;

   typedef logic [1:0] dir_t;

   localparam dir_t DIR_UP    = 2'd0;
   localparam dir_t DIR_RIGHT = 2'd1;
   localparam dir_t DIR_DOWN  = 2'd2;
   localparam dir_t DIR_LEFT  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_WAIT,
      ST_CRASH
   } state_t;

   localparam int unsigned GRID_W_DEF  = 32;
   localparam int unsigned GRID_H_DEF  = 24;
   localparam int unsigned START_X_DEF = 16;
   localparam int unsigned START_Y_DEF = 12;

   // The direction opposite to d; the encoding makes this a +2 rotation.
   function automatic dir_t dir_reverse(input dir_t d);
      return d + 2'd2;
   endfunction

endpackage

// File: rtl/snake_dir_filter.sv
// snake_dir_filter: turns button pulses into the pending direction.
//   clk, rst_n     : clock, async active-low reset
//   i_en           : accept buttons (low once the game has crashed)
//   i_btn_*        : single-cycle debounced button pulses
//   i_ref_dir      : direction that presses are checked against for reversal
//   o_pend_dir     : direction to be committed on the next tick
module snake_dir_filter
   import snake_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   input  logic i_btn_up,
   input  logic i_btn_right,
   input  logic i_btn_down,
   input  logic i_btn_left,
   input  dir_t i_ref_dir,
   output dir_t o_pend_dir
);

   dir_t r_pend_dir;
   dir_t w_pick;
   logic w_any;
   logic w_load;

   // Priority pick first; the reversal test applies only to the winner,
   // so a rejected high-priority press masks lower-priority ones.
   always_comb begin
      w_pick = DIR_UP;
      w_any  = i_btn_up | i_btn_right | i_btn_down | i_btn_left;
      if (i_btn_up)         w_pick = DIR_UP;
      else if (i_btn_right) w_pick = DIR_RIGHT;
      else if (i_btn_down)  w_pick = DIR_DOWN;
      else if (i_btn_left)  w_pick = DIR_LEFT;
      w_load = i_en && w_any && (w_pick != dir_reverse(i_ref_dir));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      r_pend_dir <= DIR_RIGHT;
      else if (w_load) r_pend_dir <= w_pick;
   end

   assign o_pend_dir = r_pend_dir;

endmodule

// File: rtl/snake_head_stepper.sv
// snake_head_stepper: advances the snake head one cell per pacemaker tick.
//   clk, rst_n   : clock, async active-low reset
//   pace         : single-cycle tick from the pacemaker
//   run          : game enable level
//   btn_*        : debounced direction button pulses
//   step_ready   : body stage accepts the offered head coordinate
//   step_valid   : new head coordinate offered
//   head_x/y     : current head cell
//   dir          : committed direction
//   crash        : sticky wall-collision flag
//   overrun      : sticky flag, tick arrived while a step was unacknowledged
module snake_head_stepper
   import snake_pkg::*;
#(
   parameter int unsigned GRID_W  = GRID_W_DEF,
   parameter int unsigned GRID_H  = GRID_H_DEF,
   parameter int unsigned XW      = 5,
   parameter int unsigned YW      = 5,
   parameter int unsigned START_X = START_X_DEF,
   parameter int unsigned START_Y = START_Y_DEF,
   parameter int unsigned WRAP    = 0
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pace,
   input  logic          run,
   input  logic          btn_up,
   input  logic          btn_right,
   input  logic          btn_down,
   input  logic          btn_left,
   input  logic          step_ready,
   output logic          step_valid,
   output logic [XW-1:0] head_x,
   output logic [YW-1:0] head_y,
   output logic [1:0]    dir,
   output logic          crash,
   output logic          overrun
);

   localparam logic [XW-1:0] X_MAX = XW'(GRID_W - 1);
   localparam logic [YW-1:0] Y_MAX = YW'(GRID_H - 1);

   state_t        r_state, w_state_nxt;
   logic [XW-1:0] r_head_x, w_head_x_nxt, w_step_x;
   logic [YW-1:0] r_head_y, w_head_y_nxt, w_step_y;
   dir_t          r_dir, w_dir_nxt, w_pend_dir, w_ref_dir;
   logic          r_step_valid, w_step_valid_nxt;
   logic          r_crash, w_crash_nxt;
   logic          r_overrun, w_overrun_nxt;
   logic          w_wall;
   logic          w_commit;

   // A press in the same cycle as a tick is checked against the direction
   // being committed, so it cannot queue a reversal of the new heading.
   assign w_commit  = (r_state == ST_RUN) && run && pace;
   assign w_ref_dir = w_commit ? w_pend_dir : r_dir;

   snake_dir_filter u_dir_filter (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_en        (r_state != ST_CRASH),
      .i_btn_up    (btn_up),
      .i_btn_right (btn_right),
      .i_btn_down  (btn_down),
      .i_btn_left  (btn_left),
      .i_ref_dir   (w_ref_dir),
      .o_pend_dir  (w_pend_dir)
   );

   // Candidate next cell; edges wrap within the grid, not within 2**XW.
   always_comb begin
      w_step_x = r_head_x;
      w_step_y = r_head_y;
      w_wall   = 1'b0;
      case (w_pend_dir)
         DIR_UP: begin
            w_wall   = (r_head_y == '0);
            w_step_y = w_wall ? Y_MAX : r_head_y - YW'(1);
         end
         DIR_RIGHT: begin
            w_wall   = (r_head_x == X_MAX);
            w_step_x = w_wall ? '0 : r_head_x + XW'(1);
         end
         DIR_DOWN: begin
            w_wall   = (r_head_y == Y_MAX);
            w_step_y = w_wall ? '0 : r_head_y + YW'(1);
         end
         default: begin
            w_wall   = (r_head_x == '0);
            w_step_x = w_wall ? X_MAX : r_head_x - XW'(1);
         end
      endcase
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_head_x_nxt     = r_head_x;
      w_head_y_nxt     = r_head_y;
      w_dir_nxt        = r_dir;
      w_step_valid_nxt = r_step_valid;
      w_crash_nxt      = r_crash;
      w_overrun_nxt    = r_overrun;
      case (r_state)
         ST_IDLE: begin
            if (run) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (!run) begin
               w_state_nxt = ST_IDLE;
            end else if (pace) begin
               w_dir_nxt = w_pend_dir;
               if (w_wall && (WRAP == 0)) begin
                  w_crash_nxt = 1'b1;
                  w_state_nxt = ST_CRASH;
               end else begin
                  w_head_x_nxt     = w_step_x;
                  w_head_y_nxt     = w_step_y;
                  w_step_valid_nxt = 1'b1;
                  w_state_nxt      = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (pace) w_overrun_nxt = 1'b1;
            if (step_ready) begin
               w_step_valid_nxt = 1'b0;
               w_state_nxt      = run ? ST_RUN : ST_IDLE;
            end
         end
         ST_CRASH: begin
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_head_x     <= XW'(START_X);
         r_head_y     <= YW'(START_Y);
         r_dir        <= DIR_RIGHT;
         r_step_valid <= 1'b0;
         r_crash      <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_head_x     <= w_head_x_nxt;
         r_head_y     <= w_head_y_nxt;
         r_dir        <= w_dir_nxt;
         r_step_valid <= w_step_valid_nxt;
         r_crash      <= w_crash_nxt;
         r_overrun    <= w_overrun_nxt;
      end
   end

   assign step_valid = r_step_valid;
   assign head_x     = r_head_x;
   assign head_y     = r_head_y;
   assign dir        = r_dir;
   assign crash      = r_crash;
   assign overrun    = r_overrun;

endmodule
